// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard/freeze controller: state encoding,
// pipeline control vector and the load-use detection rule.
package hazard_pkg;

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] MEM_WAIT = 2'd1;
    localparam logic [1:0] ERR      = 2'd2;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic stall_pc;
        logic stall_IFID;
        logic stall_disable_IDEX;
        logic flush_IFID;
        logic flush_IDEX;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE   = ctrl_t'(5'b00000);
    localparam ctrl_t CTRL_FREEZE = ctrl_t'(5'b11100);
    localparam ctrl_t CTRL_SQUASH = ctrl_t'(5'b00011);
    // Load-use bubble: front end holds while ID/EX takes a NOP.
    localparam ctrl_t CTRL_BUBBLE = ctrl_t'(5'b11001);

    function automatic logic load_use(
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       uses_rs1,
        input logic       uses_rs2,
        input logic [4:0] rd,
        input logic       mem_read
    );
        return mem_read && (rd != REG_X0) &&
               ((uses_rs1 && (rs1 == rd)) || (uses_rs2 && (rs2 == rd)));
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard-detection inputs from the pipeline and the stall/flush controls back to it.
interface hazard_ctrl_if;

    logic [4:0] rs1_IFID;
    logic [4:0] rs2_IFID;
    logic       uses_rs1_IFID;
    logic       uses_rs2_IFID;
    logic [4:0] rd_IDEX;
    logic       memRead_IDEX;
    logic       branch_taken_EX;
    logic       dmem_req;
    logic       dmem_ready;

    logic       stall_pc;
    logic       stall_IFID;
    logic       stall_disable_IDEX;
    logic       flush_IFID;
    logic       flush_IDEX;

    modport master (
        output rs1_IFID, rs2_IFID, uses_rs1_IFID, uses_rs2_IFID, rd_IDEX,
               memRead_IDEX, branch_taken_EX, dmem_req, dmem_ready,
        input  stall_pc, stall_IFID, stall_disable_IDEX, flush_IFID, flush_IDEX
    );

    modport slave (
        input  rs1_IFID, rs2_IFID, uses_rs1_IFID, uses_rs2_IFID, rd_IDEX,
               memRead_IDEX, branch_taken_EX, dmem_req, dmem_ready,
        output stall_pc, stall_IFID, stall_disable_IDEX, flush_IFID, flush_IDEX
    );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter: counts cycles with inc=1 and sticks at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + W'(1);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and freeze controller: load-use bubbles, taken-branch squashes
// and data-memory wait freezes with a timeout watchdog, plus a stall-cycle counter.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    hazard_ctrl_if.slave     hz,
    output logic             mem_timeout_err,
    output logic [CNT_W-1:0] stall_count
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    logic [1:0]        state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    ctrl_t             ctrl;
    logic              lu, mf;

    assign lu = load_use(hz.rs1_IFID, hz.rs2_IFID, hz.uses_rs1_IFID, hz.uses_rs2_IFID,
                         hz.rd_IDEX, hz.memRead_IDEX);
    assign mf = hz.dmem_req && !hz.dmem_ready;

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path infers a latch.
        ctrl         = CTRL_NONE;
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            RUN: begin
                // The freeze wins; a branch or load-use under it is re-evaluated once EX and ID resume.
                if (mf) begin
                    ctrl         = CTRL_FREEZE;
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = WAIT_W'(1);
                end else if (hz.branch_taken_EX) begin
                    ctrl = CTRL_SQUASH;
                end else if (lu) begin
                    ctrl = CTRL_BUBBLE;
                end
            end
            MEM_WAIT: begin
                ctrl = CTRL_FREEZE;
                if (hz.dmem_ready) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt >= WAIT_W'(MEM_TIMEOUT - 1)) begin
                    state_nxt = ERR;
                end else begin
                    wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            ERR:     ctrl = CTRL_FREEZE;
            default: state_nxt = RUN;
        endcase
        if (rst)
            ctrl = CTRL_NONE;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    assign hz.stall_pc           = ctrl.stall_pc;
    assign hz.stall_IFID         = ctrl.stall_IFID;
    assign hz.stall_disable_IDEX = ctrl.stall_disable_IDEX;
    assign hz.flush_IFID         = ctrl.flush_IFID;
    assign hz.flush_IDEX         = ctrl.flush_IDEX;
    assign mem_timeout_err       = (state == ERR);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (ctrl.stall_pc),
        .count (stall_count)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and randomized checks of hazard_ctrl against a cycle-level behavioural model.
module tb_hazard_ctrl;

    localparam int TO = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          err;
    logic [CW-1:0] cnt;

    int checks = 0;
    int errors = 0;

    // Model: whether a memory wait is in progress, how long the request has gone unanswered,
    // whether the watchdog has fired, and the number of stalled cycles.
    bit m_waiting;
    bit m_err;
    int m_elapsed;
    int m_count;

    hazard_ctrl_if hif ();

    hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .hz              (hif),
        .mem_timeout_err (err),
        .stall_count     (cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected {stall_pc, stall_IFID, stall_disable_IDEX, flush_IFID, flush_IDEX} this cycle.
    function automatic logic [4:0] expect_ctrl();
        bit lu;
        lu = hif.memRead_IDEX && (hif.rd_IDEX != 0) &&
             ((hif.uses_rs1_IFID && hif.rs1_IFID == hif.rd_IDEX) ||
              (hif.uses_rs2_IFID && hif.rs2_IFID == hif.rd_IDEX));
        if (rst)                                   return 5'b00000;
        if (m_err || m_waiting)                    return 5'b11100;
        if (hif.dmem_req && !hif.dmem_ready)       return 5'b11100;
        if (hif.branch_taken_EX)                   return 5'b00011;
        if (lu)                                    return 5'b11001;
        return 5'b00000;
    endfunction

    task automatic step(input string tag);
        logic [4:0] e;
        @(negedge clk);
        e = expect_ctrl();
        check({tag, "_ctrl"}, {27'd0, hif.stall_pc, hif.stall_IFID, hif.stall_disable_IDEX,
                               hif.flush_IFID, hif.flush_IDEX}, {27'd0, e});
        check({tag, "_err"}, {31'd0, err}, {31'd0, m_err});
        check({tag, "_cnt"}, {29'd0, cnt}, m_count);
        @(posedge clk);
        if (rst) begin
            m_waiting = 0; m_err = 0; m_elapsed = 0; m_count = 0;
        end else begin
            if (e[4] && m_count < (1 << CW) - 1) m_count++;
            if (!m_err) begin
                if (m_waiting) begin
                    if (hif.dmem_ready) begin
                        m_waiting = 0;
                    end else begin
                        m_elapsed++;
                        if (m_elapsed >= TO) begin
                            m_err = 1; m_waiting = 0;
                        end
                    end
                end else if (hif.dmem_req && !hif.dmem_ready) begin
                    m_waiting = 1; m_elapsed = 1;
                end
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        hif.rs1_IFID = 0; hif.rs2_IFID = 0; hif.uses_rs1_IFID = 0; hif.uses_rs2_IFID = 0;
        hif.rd_IDEX = 0; hif.memRead_IDEX = 0; hif.branch_taken_EX = 0;
        hif.dmem_req = 0; hif.dmem_ready = 0;
    endtask

    task automatic set_lu();
        hif.memRead_IDEX = 1; hif.rd_IDEX = 5; hif.rs1_IFID = 5; hif.uses_rs1_IFID = 1;
    endtask

    initial begin
        m_waiting = 0; m_err = 0; m_elapsed = 0; m_count = 0;
        rst = 1;
        idle_inputs();
        set_lu();
        #1;
        step("reset");
        rst = 0;
        idle_inputs();
        step("idle");

        set_lu();
        step("lu");
        check("lu_cnt_after", {29'd0, cnt}, 1);
        idle_inputs();

        hif.memRead_IDEX = 1; hif.rd_IDEX = 0; hif.rs1_IFID = 0; hif.uses_rs1_IFID = 1;
        step("x0");
        hif.rd_IDEX = 7; hif.rs1_IFID = 3; hif.uses_rs1_IFID = 1;
        hif.rs2_IFID = 7; hif.uses_rs2_IFID = 0;
        step("unused_rs2");
        idle_inputs();

        set_lu();
        hif.branch_taken_EX = 1;
        step("br_vs_lu");
        check("br_cnt_unchanged", {29'd0, cnt}, 1);
        idle_inputs();

        rst = 1; step("rst_mw"); rst = 0;
        hif.dmem_req = 1; hif.dmem_ready = 0;
        step("mw0");
        hif.branch_taken_EX = 1;
        step("mw1");
        step("mw2");
        hif.dmem_ready = 1;
        step("mw_ready");
        check("mw_cnt", {29'd0, cnt}, 4);
        hif.dmem_req = 0; hif.dmem_ready = 0;
        step("mw_branch");
        idle_inputs();

        hif.dmem_req = 1;
        for (int i = 0; i < TO; i++) step("to_wait");
        check("to_err_set", {31'd0, err}, 1);
        for (int i = 0; i < 4; i++) begin
            hif.dmem_ready = i[0];
            step("to_sticky");
        end
        check("to_err_sticky", {31'd0, err}, 1);
        rst = 1; step("to_rst"); rst = 0;
        idle_inputs();
        check("to_err_clr", {31'd0, err}, 0);
        check("to_cnt_clr", {29'd0, cnt}, 0);
        step("to_run");

        set_lu();
        for (int i = 0; i < 9; i++) step("sat");
        check("sat_cnt", {29'd0, cnt}, 7);
        idle_inputs();

        for (int i = 0; i < 400; i++) begin
            rst                 = ($urandom_range(0, 29) == 0);
            hif.rs1_IFID        = 5'($urandom_range(0, 3));
            hif.rs2_IFID        = 5'($urandom_range(0, 3));
            hif.uses_rs1_IFID   = 1'($urandom);
            hif.uses_rs2_IFID   = 1'($urandom);
            hif.rd_IDEX         = 5'($urandom_range(0, 3));
            hif.memRead_IDEX    = 1'($urandom);
            hif.branch_taken_EX = ($urandom_range(0, 3) == 0);
            hif.dmem_req        = ($urandom_range(0, 3) == 0);
            hif.dmem_ready      = 1'($urandom);
            step("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and freeze controller for the 5-stage RV32 core.
- Generates the stall, hold and flush controls for PC, IF/ID and ID/EX, including the `stall_disable`/`flush` inputs of the ID/EX pipeline register.
- Covers three cases: load-use bubbles, taken-branch squashes, and multi-cycle data-memory waits with a timeout watchdog.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- MEM_TIMEOUT, 255: consecutive cycles of an unanswered dmem request before the error state is entered.
- CNT_W, 32: width of the stall-cycle counter.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- rs1_IFID  in  5  rs1 field of the instruction in IF/ID.
- rs2_IFID  in  5  rs2 field of the instruction in IF/ID.
- uses_rs1_IFID  in  1  the instruction in IF/ID reads rs1.
- uses_rs2_IFID  in  1  the instruction in IF/ID reads rs2.
- rd_IDEX  in  5  destination register of the instruction in ID/EX.
- memRead_IDEX  in  1  the instruction in ID/EX is a load.
- branch_taken_EX  in  1  a branch or jump resolved as taken in EX this cycle.
- dmem_req  in  1  the MEM stage has a load or store outstanding this cycle.
- dmem_ready  in  1  data memory completes the request this cycle.
- stall_pc  out  1  PC holds its value.
- stall_IFID  out  1  IF/ID holds its value.
- stall_disable_IDEX  out  1  ID/EX holds its value (1 = hold).
- flush_IFID  out  1  IF/ID loads a NOP.
- flush_IDEX  out  1  ID/EX loads a bubble (all control bits 0).
- mem_timeout_err  out  1  sticky watchdog error flag.
- stall_count  out  CNT_W  saturating count of cycles with stall_pc=1.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state=RUN, wait_cnt=0, stall_count=0, mem_timeout_err=0. While rst=1, all control outputs are 0.
- Output timing: control outputs are combinational from state and the current inputs, so they take effect in the same cycle, at the next clock edge.
- Load-use hazard (lu): memRead_IDEX & rd_IDEX!=0 & ((uses_rs1_IFID & rs1_IFID==rd_IDEX) | (uses_rs2_IFID & rs2_IFID==rd_IDEX)).
- Memory freeze (mf): dmem_req & ~dmem_ready.
- State RUN, priority highest first:
  - mf: stall_pc=stall_IFID=stall_disable_IDEX=1, no flushes; next state MEM_WAIT, wait_cnt<=1. A simultaneous branch_taken_EX or lu is ignored this cycle; both are re-evaluated after the freeze because EX and ID are held.
  - branch_taken_EX: flush_IFID=flush_IDEX=1, all stalls 0. This overrides lu: no bubble-stall, and the PC takes the target.
  - lu: stall_pc=stall_IFID=1, flush_IDEX=1, stall_disable_IDEX=0. Exactly one bubble; lu clears the following cycle when the load moves to EX/MEM.
  - otherwise: all control outputs 0.
- State MEM_WAIT: stall_pc=stall_IFID=stall_disable_IDEX=1, no flushes, every cycle.
  - dmem_ready=1: freeze is still asserted this cycle; next state RUN, wait_cnt<=0.
  - Else if wait_cnt==MEM_TIMEOUT-1: next state ERR.
  - Else wait_cnt<=wait_cnt+1.
- State ERR: all stall/hold outputs 1, no flushes, mem_timeout_err=1. Left only by rst.
- stall_count increments in every cycle where stall_pc=1 and saturates at all-ones (no wrap). Reset clears it.
- A load-use stall and a memory wait on the same instruction do not double-stall: mf has priority and lu is re-evaluated afterwards.
- rst asserted mid-wait or in ERR returns to RUN on the next edge.

Decomposition:
- hazard_pkg holds the state enum (RUN, MEM_WAIT, ERR, 2-bit), the REG_X0 = 5'd0 constant, and the bubble control-vector constant.
- One natural sub-module, sat_counter (parameter W; ports clk, rst, inc, count), instantiated for stall_count.

Test Plan:
- Load-use: memRead_IDEX=1, rd_IDEX=5, rs1_IFID=5, uses_rs1=1 for one cycle -> stall_pc=stall_IFID=flush_IDEX=1, stall_disable_IDEX=0, stall_count 0->1.
- x0 and unused source: rd_IDEX=0 with rs1=0, or rs2 match with uses_rs2=0 -> no stall, no flush.
- Branch vs load-use: lu and branch_taken_EX in the same cycle -> flush_IFID=flush_IDEX=1, stall_pc=0, stall_count unchanged.
- Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles then ready=1 -> freeze outputs 1 for 4 cycles, state back to RUN, stall_count=4, a branch asserted during the wait is honoured in the first RUN cycle.
- Timeout: MEM_TIMEOUT=4, dmem_req=1, ready held 0 -> mem_timeout_err rises after 4 wait cycles and stays 1 with ready toggling; rst=1 for one cycle -> err=0, stall_count=0, RUN.
- Saturation: CNT_W=3, 9 stall cycles -> stall_count=7.
